// File: rtl/fetch_pkg.sv
// Shared state encoding, default geometry and counter helper for the instruction fetch unit.
package fetch_pkg;

  localparam int          ADDR_W_DEF   = 8;
  localparam int          DATA_W_DEF   = 32;
  localparam int unsigned RESET_PC_DEF = 32'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/instr_fetch_perf.sv
// Saturating handshake and stall counters for the fetch unit (used under INSTR_FETCH_PERF_CNT_EN).
module instr_fetch_perf
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // A handshake coinciding with a redirect is dropped, so it is not counted.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (instr_valid_i && instr_ready_i && !redirect_i) begin
      fetch_cnt_d = sat_inc32(fetch_cnt_q);
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (instr_valid_i && !instr_ready_i) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetcher feeding the arbiter through a valid/ready port.
// Optional perf counters: define INSTR_FETCH_PERF_CNT_EN to add fetch_cnt/stall_cnt.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DATA_W   = DATA_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] r_adrs,
  output logic              r_en,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              r_en_s;

  // Next state, datapath updates and the read strobe; redirect overrides pc and valid last.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    r_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        r_en_s = 1'b1;
        if (redirect) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          if (r_valid) begin
            state_d = fetch_en ? REQ : IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (r_valid) begin
          instr_d = data_in;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_ONE;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = fetch_en ? REQ : IDLE;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          if (fetch_en) begin
            r_en_s  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      // A redirect landing on the returning read still retires it; only the data is lost.
      DRAIN: begin
        if (r_valid) begin
          state_d = fetch_en ? REQ : IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_d;
    end
  end

  // State, pc and presented-word registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      instr_q <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign r_en        = r_en_s;
  assign r_adrs      = r_en_s ? pc_q : {ADDR_W{1'b0}};
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

`ifdef INSTR_FETCH_PERF_CNT_EN
  instr_fetch_perf u_perf (
    .clk_i         (clk),
    .rst_ni        (resetn),
    .instr_valid_i (valid_q),
    .instr_ready_i (instr_ready),
    .redirect_i    (redirect),
    .fetch_cnt_o   (fetch_cnt),
    .stall_cnt_o   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: transaction-level model, memory responder, directed and random phases.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        fetch_en, redirect, r_en, r_valid, instr_valid, instr_ready;
  logic [7:0]  redirect_pc, r_adrs, pc;
  logic [31:0] data_in, instr;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  int          hs_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  logic [7:0]  next_addr = 8'd0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .resetn      (resetn),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .r_adrs      (r_adrs),
    .r_en        (r_en),
    .r_valid     (r_valid),
    .data_in     (data_in),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc)
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'hA000_0000 + {24'd0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sig(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      step();
      if ((which == 0 && instr_valid) || (which == 1 && r_en)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Memory: answers each request after mem_lat cycles with mem_word(address).
  initial begin : mem_model
    int         cnt;
    logic [7:0] a;
    logic       req_seen;
    logic [7:0] req_a;
    cnt = 0; a = 8'd0; r_valid = 1'b0; data_in = 32'd0;
    forever begin
      @(posedge clk);
      req_seen = r_en;
      req_a    = r_adrs;
      @(negedge clk);
      r_valid = 1'b0;
      data_in = $urandom();
      if (!resetn) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            r_valid = 1'b1;
            data_in = mem_word(a);
          end
        end
        if (req_seen) begin
          a = req_a;
          if (mem_lat <= 1) begin
            r_valid = 1'b1;
            data_in = mem_word(a);
          end else begin
            cnt = mem_lat - 1;
          end
        end
      end
    end
  end

  // Reference model: tracks next request address, the outstanding read and words owed to the arbiter.
  initial begin : ref_model
    logic       outstanding, stale, prev_fe;
    logic [7:0] out_addr;
    int         idle_run;
    outstanding = 1'b0; stale = 1'b0; prev_fe = 1'b0; out_addr = 8'd0; idle_run = 0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        exp_q.delete();
        next_addr   = 8'd0;
        outstanding = 1'b0;
        stale       = 1'b0;
        prev_fe     = 1'b0;
        idle_run    = 0;
      end else begin
        if (fetch_en && !outstanding && exp_q.size() == 0 && !r_en) idle_run++;
        else idle_run = 0;
        check("fetch_progress", 32'(idle_run < 3), 32'd1);
        if (r_valid && outstanding) begin
          if (!stale && !redirect) begin
            exp_q.push_back(mem_word(out_addr));
            next_addr = out_addr + 8'd1;
          end
          outstanding = 1'b0;
          stale       = 1'b0;
        end
        if (r_en) begin
          check("r_adrs", 32'(r_adrs), 32'(next_addr));
          check("single_outstanding", 32'(outstanding), 32'd0);
          check("req_needs_fetch_en", 32'(fetch_en || prev_fe), 32'd1);
          check("no_req_while_held", 32'(exp_q.size() == 0 || (instr_ready && !redirect)), 32'd1);
          outstanding = 1'b1;
          out_addr    = r_adrs;
          stale       = 1'b0;
        end
        if (redirect) begin
          next_addr = redirect_pc;
          exp_q.delete();
          if (outstanding) stale = 1'b1;
        end
        prev_fe = fetch_en;
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted handshake and checks the presented word each cycle.
  initial begin : monitor
    logic        hs;
    logic [31:0] hs_instr;
    forever begin
      @(posedge clk);
      hs       = resetn && instr_valid && instr_ready && !redirect;
      hs_instr = instr;
      #1;
      if (hs) begin
        hs_cnt++;
        acc_q.push_back(hs_instr);
        check("word_owed", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("instr_accept", hs_instr, exp_q.pop_front());
      end
      @(negedge clk);
      if (resetn) begin
        check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("instr_held", instr, exp_q[0]);
        check("pc", 32'(pc), 32'(next_addr));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: actual=running required=finished time=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit          ok;
    int          a0, h0;
    logic [31:0] w;
    fetch_en = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'd0;
    resetn = 1'b0;
    #8;
    check("rst_r_en", 32'(r_en), 32'd0);
    check("rst_r_adrs", 32'(r_adrs), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    #2;
    resetn = 1'b1;

    // Stream at full rate with a 1-cycle memory.
    wait_sig(0, 20, ok);
    check("stream_first_valid", 32'(ok), 32'd1);
    h0 = hs_cnt;
    repeat (20) step();
    check("stream_rate", 32'(hs_cnt - h0), 32'd10);
    check("stream_word0", acc_q[0], 32'hA000_0000);
    check("stream_word1", acc_q[1], 32'hA000_0001);
    check("stream_word2", acc_q[2], 32'hA000_0002);

    // Stall for 5 cycles, then release and expect the next request in the same cycle.
    wait_sig(0, 10, ok);
    check("stall_valid_seen", 32'(ok), 32'd1);
    instr_ready = 1'b0;
    w = instr;
    repeat (5) begin
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr, w);
      check("stall_r_en", 32'(r_en), 32'd0);
    end
    instr_ready = 1'b1;
    #1;
    check("stall_release_r_en", 32'(r_en), 32'd1);
    check("stall_release_adrs", 32'(r_adrs), 32'(next_addr));

    // Wrap-around from FE.
    step();
    redirect = 1'b1; redirect_pc = 8'hFE;
    a0 = acc_q.size();
    step();
    redirect = 1'b0;
    for (int k = 0; k < 40 && acc_q.size() < a0 + 4; k++) step();
    check("wrap_fe", acc_q[a0], 32'hA000_00FE);
    check("wrap_ff", acc_q[a0 + 1], 32'hA000_00FF);
    check("wrap_00", acc_q[a0 + 2], 32'hA000_0000);
    check("wrap_01", acc_q[a0 + 3], 32'hA000_0001);

    // Redirect while a slow read is in flight.
    mem_lat = 3;
    wait_sig(1, 20, ok);
    step();
    redirect = 1'b1; redirect_pc = 8'h40;
    a0 = acc_q.size();
    step();
    redirect = 1'b0;
    wait_sig(1, 20, ok);
    check("redir_wait_req_seen", 32'(ok), 32'd1);
    check("redir_wait_adrs", 32'(r_adrs), 32'h40);
    for (int k = 0; k < 40 && acc_q.size() < a0 + 1; k++) step();
    check("redir_wait_word", acc_q[a0], 32'hA000_0040);

    // Redirect coinciding with the returning read.
    mem_lat = 1;
    wait_sig(1, 20, ok);
    step();
    redirect = 1'b1; redirect_pc = 8'h80;
    step();
    redirect = 1'b0;
    #1;
    check("redir_coin_r_en", 32'(r_en), 32'd1);
    check("redir_coin_adrs", 32'(r_adrs), 32'h80);
    check("redir_coin_pc", 32'(pc), 32'h80);

    // fetch_en drops while a read is in flight: that word is still presented, then idle.
    mem_lat = 2;
    wait_sig(1, 20, ok);
    step();
    fetch_en = 1'b0;
    a0 = acc_q.size();
    wait_sig(0, 10, ok);
    check("drop_word_presented", 32'(ok), 32'd1);
    repeat (6) begin
      step();
      check("drop_no_req", 32'(r_en), 32'd0);
    end
    check("drop_one_word", 32'(acc_q.size()), 32'(a0 + 1));

    // Asynchronous reset in the middle of a held word.
    fetch_en = 1'b1; instr_ready = 1'b0;
    wait_sig(0, 20, ok);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_r_en", 32'(r_en), 32'd0);
    check("async_rst_instr", instr, 32'd0);
    step();
    step();
    resetn = 1'b1;
    instr_ready = 1'b1;

    // Randomised traffic.
    h0 = hs_cnt;
    for (int i = 0; i < 1500; i++) begin
      step();
      fetch_en    = ($urandom_range(0, 9) < 8);
      instr_ready = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
      if (i % 100 == 0) mem_lat = $urandom_range(1, 3);
    end
    redirect = 1'b0;
    repeat (5) step();
    check("random_progress", 32'(hs_cnt - h0 > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream feeder for the instruction arbiter.
- Walks a program counter, issues single-outstanding read requests to the instruction memory port (r_adrs/r_en/r_valid), and captures returned words.
- Presents each word to the arbiter's instr input with a valid/ready handshake.
- Supports stall from the arbiter (downstream FIFOs full) and PC redirect (branch/restart).

Parameters:
- ADDR_W, 8, width of PC and memory read address.
- DATA_W, 32, instruction width; matches arbiter instr.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- fetch_en  in  1  1 = fetch allowed; 0 = finish in-flight work, then idle.
- redirect  in  1  load redirect_pc; highest priority.
- redirect_pc  in  ADDR_W  new PC.
- r_adrs  out  ADDR_W  memory read address.
- r_en  out  1  one-cycle read request strobe.
- r_valid  in  1  memory read data valid.
- data_in  in  DATA_W  memory read data.
- instr  out  DATA_W  instruction to arbiter.
- instr_valid  out  1  instr holds a valid word.
- instr_ready  in  1  arbiter accepts instr this cycle.
- pc  out  ADDR_W  address of the next word to request.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, pc=RESET_PC, r_adrs=0, r_en=0, instr=0, instr_valid=0, drop flag=0.
  - Outputs are forced immediately, not on the next clock edge.
- States:
  - IDLE: r_en=0. If fetch_en=1 -> REQ.
  - REQ: r_en=1, r_adrs=pc for exactly one cycle -> WAIT.
  - WAIT: r_en=0. On r_valid=1: instr<=data_in, instr_valid<=1, pc<=pc+1 -> HOLD.
  - HOLD: instr_valid=1, instr stable.
    - instr_ready=1 and fetch_en=1: instr_valid<=0; r_en=1, r_adrs=pc issued in the same cycle -> WAIT.
    - instr_ready=1 and fetch_en=0: instr_valid<=0 -> IDLE.
    - instr_ready=0: hold; no request is issued.
  - DRAIN: r_en=0. On r_valid=1: data discarded, instr unchanged, instr_valid stays 0 -> REQ if fetch_en=1, else IDLE.
- PC arithmetic: pc+1 is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no flag.
- Throughput and latency:
  - At most one read is outstanding at any time.
  - With 1-cycle memory and instr_ready tied high: one instruction per 2 cycles.
  - Latency from the r_valid sample to instr_valid=1 is 1 cycle.
- Stall: instr_valid and instr hold until instr_ready=1, independent of fetch_en.
- Redirect (priority over every other transition; takes effect at the clock edge where redirect=1): pc<=redirect_pc, instr_valid<=0.
  - From IDLE/HOLD: -> REQ if fetch_en=1, else IDLE. The held instr is dropped even if instr_ready=1 in the same cycle; the arbiter must not count it.
  - From REQ or WAIT (read in flight): -> DRAIN.
  - From DRAIN: pc updated, stay in DRAIN.
  - If r_valid and redirect coincide in WAIT: the returned data is discarded and the next state is REQ/IDLE per fetch_en; pc=redirect_pc, not pc+1.
- fetch_en drop mid-operation: an in-flight read still completes and is presented. Only new requests are suppressed.
- r_valid in IDLE/REQ/HOLD is a protocol error: ignored, no state change.

Optional Feature:
- Macro: INSTR_FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[31:0] (accepted handshakes, instr_valid&instr_ready with no redirect) and stall_cnt[31:0] (cycles with instr_valid=1 and instr_ready=0).
  - Both counters reset to 0 on resetn and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - state encoding localparams IDLE=0, REQ=1, WAIT=2, HOLD=3, DRAIN=4 (3 bits);
  - default ADDR_W/DATA_W;
  - RESET_PC default.
- One natural sub-module: instr_fetch_perf (the two saturating counters), instantiated only under INSTR_FETCH_PERF_CNT_EN.
- FSM, PC and output register stay in instr_fetch.

Test Plan:
- Reset and stream. Release resetn after 10 ns with fetch_en=1, instr_ready=1, mem[a]=32'hA000_0000+a -> instr sequence A0000000, A0000001, A0000002…, one valid every 2 cycles, r_adrs 0,1,2….
- Stall. After the first word is presented, hold instr_ready=0 for 5 cycles -> instr=A0000000 and instr_valid=1 stable, r_en=0 throughout; the word is accepted on release, and the next request is issued in the same cycle.
- Wrap-around. ADDR_W=8, redirect_pc=8'hFE -> words from addresses FE, FF, 00, 01; pc wraps to 0.
- Redirect in WAIT. Assert redirect with redirect_pc=8'h40 one cycle after r_en -> stale word never asserts instr_valid; the next r_en has r_adrs=40h; the first presented instr=A0000040.
- Redirect coincident with r_valid. -> word discarded, pc=redirect_pc, state REQ.
- fetch_en drop and async reset. fetch_en=0 during WAIT -> that word is presented, then IDLE with no further r_en. resetn=0 mid-HOLD -> instr_valid=0 immediately, pc=RESET_PC.
